mc_hs_retry_ctrl: RTL and testbench
===================================

Name: mc_hs_retry_ctrl

Overview:
- Parametrised multi-channel successor to the single-channel req/ack/retry/busy/endtx handshake controller.
- Arbitrates NCH requesters round-robin and issues a one-cycle ack to the winner.
- Holds busy for the transfer until endtx.
- Handles target retry with bounded backoff and a retry limit, and flags retry-limit and timeout errors.
- Sits between initiator channels and a shared target, and serves as the DUT for handshake SVA benches.

Parameters:
NCH, 4, number of requesting channels (2..16)
MAX_RETRY, 3, retries allowed per transaction before abort (1..15)
BACKOFF_CYC, 2, cycles spent in BACKOFF after each retry (>=1)
TIMEOUT, 32, max cycles in BUSY before abort (>=2)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req  in  NCH  per-channel request, level, held until acked transfer ends
retry  in  1  target asks current transfer to be retried (sampled only in BUSY)
endtx  in  1  target signals transfer end (sampled only in BUSY)
ack  out  NCH  one-hot grant pulse, one cycle
busy  out  1  transfer in progress
gnt_id  out  $clog2(NCH)  index of channel owning current/last grant
err_retry  out  1  one-cycle pulse: retry limit exceeded, transaction aborted
err_tout  out  1  one-cycle pulse: BUSY timeout, transaction aborted

Behaviour:
- Reset (rst=1 at posedge): all outputs 0; state IDLE; rr pointer 0 (channel 0 highest priority); retry_cnt 0; timer 0. rst overrides everything mid-transfer, with no error pulse.
- All outputs are registered, decoded from state and registers.
- State IDLE:
  - If any req is high, pick the first set bit at or after the rr pointer (wrapping) and set gnt_id.
  - Go to ACK. req seen at cycle n gives ack at n+1.
- State ACK: ack[gnt_id]=1 for exactly one cycle, then go to BUSY. Clear timer.
- State BUSY:
  - busy=1 and the timer increments.
  - endtx=1: go to IDLE, rr pointer := gnt_id+1 (mod NCH), retry_cnt := 0.
  - Otherwise retry=1 and retry_cnt<MAX_RETRY: retry_cnt++ and go to BACKOFF.
  - Otherwise retry=1 and retry_cnt==MAX_RETRY: err_retry pulse, go to IDLE, advance the pointer, clear retry_cnt.
  - Otherwise timer==TIMEOUT-1: err_tout pulse, go to IDLE, advance the pointer, clear retry_cnt.
  - endtx and retry together: endtx wins, no retry counted.
  - endtx and timeout together: endtx wins.
- State BACKOFF:
  - busy=0; count BACKOFF_CYC cycles.
  - At the end, if req[gnt_id] is still high, go to ACK with the same gnt_id (no re-arbitration).
  - If it has dropped, go to IDLE, advance the pointer, clear retry_cnt, no error.
- req[gnt_id] dropping during ACK/BUSY is ignored; the transfer runs to endtx/abort.
- Minimum gap: after endtx at cycle n, IDLE at n+1, next ack earliest at n+2.
- ack is never asserted while busy=1. At most one ack bit is ever set.
- gnt_id holds its value through IDLE until the next grant.

Decomposition:
- Package hs_pkg: state enum (IDLE, ACK, BUSY, BACKOFF) and a width helper function for the clog2 of NCH.
- Sub-module rr_arb: combinational round-robin first-set-bit search from the pointer. Inputs are req and ptr; outputs are valid and idx.
- The top level holds the FSM, counters and output registers.

Test Plan:
All tests use NCH=4, MAX_RETRY=2, BACKOFF_CYC=3, TIMEOUT=16.
1. Reset then req=4'b0100 at cycle 0 -> ack=4'b0100 at cycle 1, gnt_id=2, busy=1 at cycles 2..k; endtx at k -> busy=0 at k+1.
2. req=4'b1111 held, endtx 3 cycles after each ack -> grants in order 0,1,2,3,0, each ack separated by ≥5 cycles.
3. Single req ch1, retry in BUSY twice -> 3 cycles busy=0 after each, re-ack ch1 twice; third retry -> err_retry pulse, no further ack to ch1 while ch3 pending gets next ack.
4. ch0 granted, no endtx/retry for 16 BUSY cycles -> err_tout at the 16th, busy=0 next cycle, pointer now 1.
5. endtx and retry same cycle -> normal completion, no BACKOFF, err_* stay 0. Also: req dropped during BACKOFF -> IDLE, no ack, no error.
6. rst asserted during BUSY and during BACKOFF -> next cycle all outputs 0, ch0 wins next arbitration with req=4'b1001.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared types and helpers for the multi-channel req/ack/retry handshake controller.
package hs_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StBusy,
        StBackoff
    } hs_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first set request bit at or after ptr, wrapping.
module rr_arb #(
    parameter int unsigned NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic                   valid,
    output logic [$clog2(NCH)-1:0] idx
);

    localparam int unsigned IW = $clog2(NCH);

    always_comb begin
        int unsigned j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            j = 32'(ptr) + i;
            if (j >= NCH) begin
                j = j - NCH;
            end
            if (!valid && req[IW'(j)]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mc_hs_retry_ctrl.sv
// Multi-channel handshake controller: round-robin grant, busy until endtx,
// bounded retry with backoff, retry-limit and busy-timeout aborts.
module mc_hs_retry_ctrl
    import hs_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned BACKOFF_CYC = 2,
    parameter int unsigned TIMEOUT     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         req,
    input  logic                   retry,
    input  logic                   endtx,
    output logic [NCH-1:0]         ack,
    output logic                   busy,
    output logic [$clog2(NCH)-1:0] gnt_id,
    output logic                   err_retry,
    output logic                   err_tout
);

    localparam int unsigned IW = $clog2(NCH);
    localparam int unsigned RW = clog2w(MAX_RETRY + 1);
    localparam int unsigned TW = clog2w(TIMEOUT);
    localparam int unsigned BW = clog2w(BACKOFF_CYC);

    hs_state_e      state_q, state_d;
    logic [IW-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [RW-1:0]  rcnt_q, rcnt_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [BW-1:0]  bo_q, bo_d;
    logic [NCH-1:0] ack_q, ack_d;
    logic           busy_q, busy_d;
    logic           err_retry_q, err_retry_d;
    logic           err_tout_q, err_tout_d;

    logic           arb_valid;
    logic [IW-1:0]  arb_idx;
    logic [IW-1:0]  ptr_adv;

    rr_arb #(
        .NCH(NCH)
    ) u_arb (
        .req  (req),
        .ptr  (ptr_q),
        .valid(arb_valid),
        .idx  (arb_idx)
    );

    // Priority moves to the channel after the one just served.
    always_comb begin
        ptr_adv = (gnt_q == IW'(NCH - 1)) ? '0 : gnt_q + IW'(1);
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        rcnt_d      = rcnt_q;
        tmr_d       = tmr_q;
        bo_d        = bo_q;
        err_retry_d = 1'b0;
        err_tout_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    gnt_d   = arb_idx;
                    state_d = StAck;
                end
            end
            StAck: begin
                tmr_d   = '0;
                state_d = StBusy;
            end
            StBusy: begin
                tmr_d = tmr_q + TW'(1);
                if (endtx) begin
                    state_d = StIdle;
                    ptr_d   = ptr_adv;
                    rcnt_d  = '0;
                end else if (retry && (rcnt_q < RW'(MAX_RETRY))) begin
                    rcnt_d  = rcnt_q + RW'(1);
                    bo_d    = '0;
                    state_d = StBackoff;
                end else if (retry) begin
                    err_retry_d = 1'b1;
                    state_d     = StIdle;
                    ptr_d       = ptr_adv;
                    rcnt_d      = '0;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    err_tout_d = 1'b1;
                    state_d    = StIdle;
                    ptr_d      = ptr_adv;
                    rcnt_d     = '0;
                end
            end
            StBackoff: begin
                bo_d = bo_q + BW'(1);
                if (bo_q == BW'(BACKOFF_CYC - 1)) begin
                    // Retries stay with the same channel; no re-arbitration.
                    if (req[gnt_q]) begin
                        state_d = StAck;
                    end else begin
                        state_d = StIdle;
                        ptr_d   = ptr_adv;
                        rcnt_d  = '0;
                    end
                end
            end
        endcase

        ack_d  = (state_d == StAck) ? ({{(NCH - 1){1'b0}}, 1'b1} << gnt_d) : '0;
        busy_d = (state_d == StBusy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            ptr_q       <= '0;
            rcnt_q      <= '0;
            tmr_q       <= '0;
            bo_q        <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            err_retry_q <= 1'b0;
            err_tout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            rcnt_q      <= rcnt_d;
            tmr_q       <= tmr_d;
            bo_q        <= bo_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            err_retry_q <= err_retry_d;
            err_tout_q  <= err_tout_d;
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign gnt_id    = gnt_q;
    assign err_retry = err_retry_q;
    assign err_tout  = err_tout_q;

endmodule

// File: tb/tb_mc_hs_retry_ctrl.sv
// Directed bench for mc_hs_retry_ctrl with NCH=4, MAX_RETRY=2, BACKOFF_CYC=3, TIMEOUT=16.
module tb_mc_hs_retry_ctrl;

    localparam int unsigned NCH         = 4;
    localparam int unsigned MAX_RETRY   = 2;
    localparam int unsigned BACKOFF_CYC = 3;
    localparam int unsigned TIMEOUT     = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       retry;
    logic       endtx;
    logic [3:0] ack;
    logic       busy;
    logic [1:0] gnt_id;
    logic       err_retry;
    logic       err_tout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mc_hs_retry_ctrl #(
        .NCH        (NCH),
        .MAX_RETRY  (MAX_RETRY),
        .BACKOFF_CYC(BACKOFF_CYC),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .retry    (retry),
        .endtx    (endtx),
        .ack      (ack),
        .busy     (busy),
        .gnt_id   (gnt_id),
        .err_retry(err_retry),
        .err_tout (err_tout)
    );

    // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_ack, input logic e_busy,
                           input logic [1:0] e_gnt, input logic e_er, input logic e_et);
        chk({tag, ".ack"}, 32'(ack), 32'(e_ack));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".gnt_id"}, 32'(gnt_id), 32'(e_gnt));
        chk({tag, ".err_retry"}, 32'(err_retry), 32'(e_er));
        chk({tag, ".err_tout"}, 32'(err_tout), 32'(e_et));
    endtask

    initial begin
        rst   = 1'b1;
        req   = 4'b0000;
        retry = 1'b0;
        endtx = 1'b0;
        tick(2);
        chk_all("reset", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single request, ack next cycle, busy until endtx, gnt_id held in IDLE.
        req = 4'b0100;
        tick();
        chk_all("t1_ack", 4'b0100, 1'b0, 2'd2, 1'b0, 1'b0);
        tick();
        chk_all("t1_busy_first", 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0);
        tick(2);
        chk_all("t1_busy_last", 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0);
        endtx = 1'b1;
        tick();
        endtx = 1'b0;
        req   = 4'b0000;
        chk_all("t1_end", 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
        tick();
        chk_all("t1_idle_hold", 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);

        // All channels requesting: rotation 0,1,2,3,0 with 5-cycle ack spacing.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_all("t2_ack", 4'(1 << (k % 4)), 1'b0, 2'(k % 4), 1'b0, 1'b0);
            tick();
            chk_all("t2_busy", 4'b0000, 1'b1, 2'(k % 4), 1'b0, 1'b0);
            tick(2);
            endtx = 1'b1;
            tick();
            endtx = 1'b0;
            if (k == 4) req = 4'b0000;
            chk_all("t2_gap", 4'b0000, 1'b0, 2'(k % 4), 1'b0, 1'b0);
        end

        // Retries on ch1: two backoffs then the retry limit aborts; pending ch3 wins next.
        req = 4'b0010;
        tick();
        chk_all("t3_ack", 4'b0010, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        chk_all("t3_busy1", 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
        retry = 1'b1;
        tick();
        retry = 1'b0;
        chk_all("t3_bo1_c0", 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        chk_all("t3_bo1_c1", 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        chk_all("t3_bo1_c2", 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        chk_all("t3_reack1", 4'b0010, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        chk_all("t3_busy2", 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
        retry = 1'b1;
        req   = 4'b1010;
        tick();
        retry = 1'b0;
        chk_all("t3_bo2_c0", 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        chk_all("t3_bo2_c1", 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        chk_all("t3_bo2_c2", 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        chk_all("t3_reack2", 4'b0010, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        chk_all("t3_busy3", 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
        retry = 1'b1;
        tick();
        retry = 1'b0;
        chk_all("t3_err_retry", 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0);
        tick();
        chk_all("t3_ch3_ack", 4'b1000, 1'b0, 2'd3, 1'b0, 1'b0);
        tick();
        chk_all("t3_ch3_busy", 4'b0000, 1'b1, 2'd3, 1'b0, 1'b0);
        endtx = 1'b1;
        tick();
        endtx = 1'b0;
        req   = 4'b0000;
        chk_all("t3_end", 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);

        // Timeout: 16 busy cycles, then err_tout with busy low; pointer moves to ch1.
        req = 4'b0001;
        tick();
        chk_all("t4_ack", 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_all("t4_busy", 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        tick();
        chk_all("t4_tout", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
        req = 4'b0011;
        tick();
        chk_all("t4_ptr", 4'b0010, 1'b0, 2'd1, 1'b0, 1'b0);
        tick();
        endtx = 1'b1;
        tick();
        endtx = 1'b0;
        req   = 4'b0000;
        chk_all("t4_end", 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);

        // endtx and retry together complete normally; next grant follows immediately.
        req = 4'b0100;
        tick();
        chk_all("t5_ack", 4'b0100, 1'b0, 2'd2, 1'b0, 1'b0);
        tick();
        endtx = 1'b1;
        retry = 1'b1;
        tick();
        endtx = 1'b0;
        retry = 1'b0;
        chk_all("t5_both", 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
        req = 4'b1100;
        tick();
        chk_all("t5_next", 4'b1000, 1'b0, 2'd3, 1'b0, 1'b0);
        tick();
        endtx = 1'b1;
        tick();
        endtx = 1'b0;
        req   = 4'b0000;
        chk_all("t5_end", 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);

        // Request dropped during backoff: back to IDLE, no ack, no error, pointer advanced.
        req = 4'b0001;
        tick();
        chk_all("t5b_ack", 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        retry = 1'b1;
        tick();
        retry = 1'b0;
        req   = 4'b0000;
        chk_all("t5b_bo_c0", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("t5b_bo_c1", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("t5b_bo_c2", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("t5b_drop", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        req = 4'b0011;
        tick();
        chk_all("t5b_ptr", 4'b0010, 1'b0, 2'd1, 1'b0, 1'b0);

        // Reset during BUSY, then during BACKOFF; ch0 wins afterwards.
        tick();
        chk_all("t6_busy", 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
        rst = 1'b1;
        req = 4'b1001;
        tick();
        rst = 1'b0;
        chk_all("t6_rst_busy", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("t6_ack0_a", 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        endtx = 1'b1;
        tick();
        endtx = 1'b0;
        req   = 4'b1000;
        tick();
        chk_all("t6_ack3", 4'b1000, 1'b0, 2'd3, 1'b0, 1'b0);
        tick();
        retry = 1'b1;
        tick();
        retry = 1'b0;
        chk_all("t6_bo", 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        req = 4'b1001;
        tick();
        rst = 1'b0;
        chk_all("t6_rst_bo", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        chk_all("t6_ack0_b", 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0);
        req = 4'b0000;
        tick();
        endtx = 1'b1;
        tick();
        endtx = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
